ksa_rr_sched: RTL

- Shares one 32-bit prefix-adder datapath among NREQ requesters.
- Round-robin arbitration selects one requester per cycle; the winner's operands enter a two-stage pipeline: operand register, then add, then result register.
- Results return on a single valid/ready response channel, tagged with the requester index.
- Sits between client units and the adder so that only one adder instance is needed per cluster.

---
 rtl/ksa_rr_sched.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ksa_rr_sched.sv
// Round-robin scheduler sharing one Kogge-Stone prefix adder among NREQ requesters.
// Two-stage pipeline (operand register, result register) with a tagged valid/ready response.
module ksa_rr_sched #(
    parameter int NREQ = 4,
    parameter int W    = 32,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [W-1:0]        rsp_s,
    output logic [IDW-1:0]      rsp_id,
    output logic                idle
);

    // Kogge-Stone generate/propagate prefix tree; carry-in is 0 and carry-out is dropped.
    function automatic logic [W-1:0] ksa_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] g;
        logic [W-1:0] p;
        logic [W-1:0] g_prev;
        logic [W-1:0] p_prev;
        g = a & b;
        p = a ^ b;
        for (int d = 1; d < W; d = d * 2) begin
            g_prev = g;
            p_prev = p;
            for (int i = d; i < W; i++) begin
                g[i] = g_prev[i] | (p_prev[i] & g_prev[i-d]);
                p[i] = p_prev[i] & p_prev[i-d];
            end
        end
        return (a ^ b) ^ {g[W-2:0], 1'b0};
    endfunction

    logic             va_q, va_d;
    logic [W-1:0]     opa_a_q, opa_a_d;
    logic [W-1:0]     opa_b_q, opa_b_d;
    logic [IDW-1:0]   opa_id_q, opa_id_d;
    logic             vr_q, vr_d;
    logic [W-1:0]     rsp_s_q, rsp_s_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [IDW-1:0]   ptr_q, ptr_d;

    logic             any_valid;
    logic             hi_found;
    logic [IDW-1:0]   hi_idx;
    logic [IDW-1:0]   lo_idx;
    logic [IDW-1:0]   grant_idx;
    logic [NREQ-1:0]  grant_onehot;
    logic [W-1:0]     sel_a;
    logic [W-1:0]     sel_b;
    logic [W-1:0]     sum;
    logic             r_load;
    logic             adv_a;
    logic             accept;

    // Lowest valid index at or above ptr wins; otherwise wrap to the lowest valid index overall.
    always_comb begin
        any_valid = |req_valid;
        hi_found  = 1'b0;
        hi_idx    = '0;
        lo_idx    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_idx = IDW'(i);
            end
            if (req_valid[i] && (i >= int'(ptr_q))) begin
                hi_found = 1'b1;
                hi_idx   = IDW'(i);
            end
        end
        grant_idx    = hi_found ? hi_idx : lo_idx;
        grant_onehot = NREQ'(1) << grant_idx;
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == grant_idx) begin
                sel_a = req_a[i*W +: W];
                sel_b = req_b[i*W +: W];
            end
        end
    end

    assign sum = ksa_add(opa_a_q, opa_b_q);

    always_comb begin
        r_load    = va_q & (~vr_q | rsp_ready);
        adv_a     = ~va_q | r_load;
        accept    = adv_a & any_valid & reset;
        req_ready = accept ? grant_onehot : '0;

        va_d     = va_q;
        opa_a_d  = opa_a_q;
        opa_b_d  = opa_b_q;
        opa_id_d = opa_id_q;
        vr_d     = vr_q;
        rsp_s_d  = rsp_s_q;
        rsp_id_d = rsp_id_q;
        ptr_d    = ptr_q;

        if (adv_a) begin
            va_d = accept;
        end
        if (accept) begin
            opa_a_d  = sel_a;
            opa_b_d  = sel_b;
            opa_id_d = grant_idx;
            ptr_d    = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
        end

        // A fresh result may replace one being consumed on the same edge.
        if (r_load) begin
            vr_d     = 1'b1;
            rsp_s_d  = sum;
            rsp_id_d = opa_id_q;
        end else if (vr_q && rsp_ready) begin
            vr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            va_q     <= 1'b0;
            opa_a_q  <= '0;
            opa_b_q  <= '0;
            opa_id_q <= '0;
            vr_q     <= 1'b0;
            rsp_s_q  <= '0;
            rsp_id_q <= '0;
            ptr_q    <= '0;
        end else begin
            va_q     <= va_d;
            opa_a_q  <= opa_a_d;
            opa_b_q  <= opa_b_d;
            opa_id_q <= opa_id_d;
            vr_q     <= vr_d;
            rsp_s_q  <= rsp_s_d;
            rsp_id_q <= rsp_id_d;
            ptr_q    <= ptr_d;
        end
    end

    assign rsp_valid = vr_q;
    assign rsp_s     = rsp_s_q;
    assign rsp_id    = rsp_id_q;
    assign idle      = ~va_q & ~vr_q;

endmodule
